mac_kbd_link: RTL and testbench

MAC_KBD_LINK -- requirements
Module: mac_kbd_link

---
 rtl/mac_kbd_link.sv | 185 ++++++++++++++++++
 tb/tb_mac_kbd_link.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_kbd_link.sv
// rtl/mac_kbd_link.sv - keyboard-side serial link: receives host commands, returns core responses
module mac_kbd_link #(
  parameter int          T_LO         = 16,
  parameter int          T_HI         = 16,
  parameter logic [21:0] RESP_TIMEOUT = 22'h3FFFF0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  output logic       kbd_clk,
  output logic       kbd_dout,
  input  logic       kbd_din,
  output logic [7:0] data_out,
  output logic       strobe_out,
  input  logic [7:0] data_in,
  input  logic       strobe_in,
  output logic       busy
);

  // Phase counters count down from the load value, so a phase lasts load+1 ticks.
  localparam logic [15:0] LO_LOAD = 16'(T_LO - 1);
  localparam logic [15:0] HI_LOAD = 16'(T_HI - 1);
  localparam logic [21:0] TO_LAST = RESP_TIMEOUT - 22'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_LO,
    S_RX_HI,
    S_CMD,
    S_WAIT,
    S_TX_LO,
    S_TX_HI
  } state_t;

  state_t      state_q, state_d;
  logic        din_meta_q, din_s_q;
  logic        low_q, low_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] phase_q, phase_d;
  logic [21:0] to_q, to_d;
  logic [7:0]  sr_q, sr_d;
  logic        dout_q, dout_d;
  logic [7:0]  data_out_q, data_out_d;

  // Two-flop synchronizer for the asynchronous host data line; runs every clk.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      din_meta_q <= 1'b1;
      din_s_q    <= 1'b1;
    end else begin
      din_meta_q <= kbd_din;
      din_s_q    <= din_meta_q;
    end
  end

  // State and datapath registers; everything holds while ce is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      low_q      <= 1'b0;
      bit_q      <= 3'd0;
      phase_q    <= 16'd0;
      to_q       <= 22'd0;
      sr_q       <= 8'h00;
      dout_q     <= 1'b1;
      data_out_q <= 8'h00;
    end else if (ce) begin
      state_q    <= state_d;
      low_q      <= low_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      to_q       <= to_d;
      sr_q       <= sr_d;
      dout_q     <= dout_d;
      data_out_q <= data_out_d;
    end
  end

  // Next-state and datapath updates for one ce tick.
  always_comb begin
    state_d    = state_q;
    low_d      = low_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    to_d       = to_q;
    sr_d       = sr_q;
    dout_d     = dout_q;
    data_out_d = data_out_q;
    case (state_q)
      S_IDLE: begin
        // A start request must be low on two consecutive ticks to count.
        if (!din_s_q) begin
          if (low_q) begin
            state_d = S_RX_LO;
            bit_d   = 3'd0;
            phase_d = LO_LOAD;
            low_d   = 1'b0;
          end else begin
            low_d = 1'b1;
          end
        end else begin
          low_d = 1'b0;
        end
      end
      S_RX_LO: begin
        if (phase_q == 16'd0) begin
          state_d = S_RX_HI;
          phase_d = HI_LOAD;
        end else begin
          phase_d = phase_q - 16'd1;
        end
      end
      S_RX_HI: begin
        // Sample host data once, on the first high tick, MSB first.
        if (phase_q == HI_LOAD) begin
          sr_d = {sr_q[6:0], din_s_q};
        end
        if (phase_q == 16'd0) begin
          if (bit_q == 3'd7) begin
            state_d    = S_CMD;
            data_out_d = sr_d;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = S_RX_LO;
            phase_d = LO_LOAD;
          end
        end else begin
          phase_d = phase_q - 16'd1;
        end
      end
      S_CMD: begin
        state_d = S_WAIT;
        to_d    = 22'd0;
      end
      S_WAIT: begin
        if (strobe_in) begin
          sr_d    = data_in;
          bit_d   = 3'd0;
          phase_d = LO_LOAD;
          dout_d  = data_in[7];
          state_d = S_TX_LO;
        end else if (to_q >= TO_LAST) begin
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 22'd1;
        end
      end
      S_TX_LO: begin
        if (phase_q == 16'd0) begin
          state_d = S_TX_HI;
          phase_d = HI_LOAD;
        end else begin
          phase_d = phase_q - 16'd1;
        end
      end
      S_TX_HI: begin
        if (phase_q == 16'd0) begin
          sr_d = {sr_q[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            state_d = S_IDLE;
            dout_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            dout_d  = sr_q[6];
            state_d = S_TX_LO;
            phase_d = LO_LOAD;
          end
        end else begin
          phase_d = phase_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; the command strobe is qualified by ce so it lasts one tick.
  always_comb begin
    kbd_clk    = !((state_q == S_RX_LO) || (state_q == S_TX_LO));
    kbd_dout   = dout_q;
    data_out   = data_out_q;
    strobe_out = (state_q == S_CMD) && ce;
    busy       = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_mac_kbd_link.sv
// tb/tb_mac_kbd_link.sv - scoreboard bench for mac_kbd_link
module tb_mac_kbd_link;

  localparam int          T_LO = 4;
  localparam int          T_HI = 4;
  localparam logic [21:0] RT   = 22'd64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b1;
  logic       kbd_din = 1'b1;
  logic       strobe_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       kbd_clk, kbd_dout, strobe_out, busy;
  logic [7:0] data_out;

  mac_kbd_link #(.T_LO(T_LO), .T_HI(T_HI), .RESP_TIMEOUT(RT)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .kbd_clk(kbd_clk), .kbd_dout(kbd_dout),
    .kbd_din(kbd_din), .data_out(data_out), .strobe_out(strobe_out),
    .data_in(data_in), .strobe_in(strobe_in), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic dout;
    int   len;
  } pulse_t;

  pulse_t     pulse_q[$];
  logic [7:0] cmd_q[$];
  int         checks = 0;
  int         failures = 0;
  logic       ce_toggle = 1'b0;
  int         mon_lo = 0;
  logic       mon_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // ce driver: steady high, or alternating every clk when ce_toggle is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ce_toggle) ce = ~ce;
      else ce = 1'b1;
    end
  end

  // Monitor: pops expected command bytes on strobe and expected bits on each kbd_clk rise.
  initial begin
    pulse_t p;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_lo   = 0;
        mon_prev = 1'b1;
      end else begin
        if (strobe_out) begin
          if (cmd_q.size() == 0) fail_now("unexpected_strobe");
          else check("cmd_byte", data_out, cmd_q.pop_front());
        end
        if (kbd_clk == 1'b0) begin
          mon_lo++;
        end else if (mon_prev == 1'b0) begin
          if (pulse_q.size() == 0) begin
            fail_now("unexpected_kbd_clk_pulse");
          end else begin
            p = pulse_q.pop_front();
            check("pulse_dout", kbd_dout, p.dout);
            check("pulse_low_len", mon_lo, p.len);
          end
          mon_lo = 0;
        end
        mon_prev = kbd_clk;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  task automatic wait_level(input logic lvl);
    int n = 0;
    while (kbd_clk !== lvl && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (kbd_clk !== lvl) fail_now("kbd_clk_wait_timeout");
  endtask

  task automatic host_send(input logic [7:0] b, input int len);
    for (int i = 0; i < 8; i++) pulse_q.push_back('{1'b1, len});
    cmd_q.push_back(b);
    kbd_din = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      wait_level(1'b0);
      kbd_din = b[i];
      wait_level(1'b1);
    end
  endtask

  task automatic wait_strobe();
    int n = 0;
    while (strobe_out !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (strobe_out !== 1'b1) fail_now("strobe_wait_timeout");
    kbd_din = 1'b1;
  endtask

  task automatic respond(input logic [7:0] d, input int dly, input int hold, input int len);
    repeat (dly) @(negedge clk);
    for (int i = 7; i >= 0; i--) pulse_q.push_back('{d[i], len});
    strobe_in = 1'b1;
    data_in   = d;
    repeat (hold) @(negedge clk);
    strobe_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) fail_now("idle_wait_timeout");
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_kbd_clk"}, kbd_clk, 1'b1);
    check({tag, "_kbd_dout"}, kbd_dout, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    logic busy_seen, clk_low_seen;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_strobe_out", strobe_out, 1'b0);
    check("reset_data_out", data_out, 8'h00);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single-tick low on kbd_din is not a start request.
    kbd_din = 1'b0;
    @(negedge clk);
    kbd_din = 1'b1;
    busy_seen = 1'b0;
    clk_low_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
      clk_low_seen = clk_low_seen | ~kbd_clk;
    end
    check("glitch_busy_seen", busy_seen, 1'b0);
    check("glitch_clk_low_seen", clk_low_seen, 1'b0);

    // Command 0x10 with no response: times out after 64 WAIT ticks.
    host_send(8'h10, 4);
    wait_strobe();
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("timeout_wait_ticks", n, 64);
    check_idle("timeout");
    repeat (5) @(negedge clk);

    // Command 0x14, response 0x7B ten ticks after the strobe.
    host_send(8'h14, 4);
    wait_strobe();
    respond(8'h7B, 10, 1, 4);
    wait_idle();
    check_idle("resp7b");
    repeat (5) @(negedge clk);

    // strobe_in on the CMD tick is ignored; the one on the first WAIT tick is taken.
    host_send(8'h5A, 4);
    wait_strobe();
    strobe_in = 1'b1;
    data_in   = 8'h00;
    @(negedge clk);
    for (int i = 7; i >= 0; i--) pulse_q.push_back('{data_in_a5(i), 4});
    data_in = 8'hA5;
    @(negedge clk);
    strobe_in = 1'b0;
    wait_idle();
    check_idle("resp_a5");
    repeat (5) @(negedge clk);

    // Reset during the third transmitted bit, then a normal transfer.
    host_send(8'h14, 4);
    wait_strobe();
    respond(8'h7B, 10, 1, 4);
    wait_level(1'b0);
    wait_level(1'b1);
    wait_level(1'b0);
    wait_level(1'b1);
    wait_level(1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle("midreset");
    check("midreset_strobe_out", strobe_out, 1'b0);
    check("midreset_data_out", data_out, 8'h00);
    pulse_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    host_send(8'h3C, 4);
    wait_strobe();
    respond(8'hC3, 5, 1, 4);
    wait_idle();
    check_idle("after_reset");
    repeat (5) @(negedge clk);

    // Same 0x14/0x7B exchange with ce alternating every clk.
    ce_toggle = 1'b1;
    repeat (4) @(negedge clk);
    host_send(8'h14, 8);
    wait_strobe();
    respond(8'h7B, 20, 2, 8);
    wait_idle();
    check_idle("ce_toggle");
    ce_toggle = 1'b0;
    repeat (10) @(negedge clk);

    check("pulse_queue_drained", pulse_q.size(), 0);
    check("cmd_queue_drained", cmd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic data_in_a5(input int i);
    logic [7:0] v;
    v = 8'hA5;
    return v[i];
  endfunction

endmodule
